// File: rtl/m_loader_pkg.sv
// Shared state encodings and stream framing constants for the instruction-memory loader.
package m_loader_pkg;

    typedef enum logic [2:0] {
        S_HDR0 = 3'd0,
        S_HDR1 = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int LANE_W     = $clog2(WORD_BYTES);

endpackage

// File: rtl/m_imem_loader_if.sv
// Byte-stream input, instruction-memory write port and core-control outputs of the loader.
interface m_imem_loader_if #(
    parameter int ADDR_W = 12
);
    logic              w_in_valid;
    logic [7:0]        w_in_data;
    logic              w_in_ready;
    logic              w_restart;
    logic              w_we;
    logic [ADDR_W-1:0] w_wa;
    logic [31:0]       w_wd;
    logic              w_cpu_rst_n;
    logic              w_done;
    logic              w_err;

    modport slave (
        input  w_in_valid, w_in_data, w_restart,
        output w_in_ready, w_we, w_wa, w_wd, w_cpu_rst_n, w_done, w_err
    );

    modport master (
        output w_in_valid, w_in_data, w_restart,
        input  w_in_ready, w_we, w_wa, w_wd, w_cpu_rst_n, w_done, w_err
    );
endinterface

// File: rtl/m_byte_packer.sv
// Assembles accepted bytes into little-endian 32-bit words; strobes on the last byte of each word.
module m_byte_packer
    import m_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        acc,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_done
);
    logic [LANE_W-1:0] lane;
    logic [23:0]       sr;

    // Bytes enter at the top so the first byte of a word ends up in [7:0].
    assign word      = {data, sr};
    assign word_done = acc && (lane == LANE_W'(WORD_BYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane <= '0;
            sr   <= '0;
        end else if (clr) begin
            lane <= '0;
            sr   <= '0;
        end else if (acc) begin
            lane <= lane + LANE_W'(1);
            sr   <= {data, sr[23:8]};
        end
    end
endmodule

// File: rtl/m_imem_loader.sv
// Loads a counted, checksummed byte image into instruction memory and releases core reset on success.
module m_imem_loader
    import m_loader_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic w_clk,
    input  logic w_rst_n,
    m_imem_loader_if.slave bus
);
    localparam logic [16:0]     DEPTH_L = 17'(DEPTH);
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    logic [7:0]        cnt_lo;
    logic [7:0]        csum;
    logic [ADDR_W:0]   n_words;
    logic [ADDR_W:0]   word_idx;
    logic [ADDR_W:0]   idx_nxt;
    logic [15:0]       n_full;
    logic              rdy;
    logic              acc;
    logic              restart_ok;
    logic [31:0]       word;
    logic              word_done;

    assign acc        = bus.w_in_valid && rdy;
    assign n_full     = {bus.w_in_data, cnt_lo};
    assign idx_nxt    = word_idx + ONE;
    assign restart_ok = bus.w_restart && (state == S_DONE || state == S_ERR);
    assign bus.w_in_ready = rdy;

    m_byte_packer u_packer (
        .clk       (w_clk),
        .rst_n     (w_rst_n),
        .clr       (restart_ok),
        .acc       (acc && state == S_DATA),
        .data      (bus.w_in_data),
        .word      (word),
        .word_done (word_done)
    );

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state           <= S_HDR0;
            cnt_lo          <= '0;
            csum            <= '0;
            n_words         <= '0;
            word_idx        <= '0;
            rdy             <= 1'b1;
            bus.w_we        <= 1'b0;
            bus.w_wa        <= '0;
            bus.w_wd        <= '0;
            bus.w_cpu_rst_n <= 1'b0;
            bus.w_done      <= 1'b0;
            bus.w_err       <= 1'b0;
        end else begin
            bus.w_we <= 1'b0;
            case (state)
                S_HDR0: if (acc) begin
                    cnt_lo <= bus.w_in_data;
                    csum   <= csum ^ bus.w_in_data;
                    state  <= S_HDR1;
                end
                S_HDR1: if (acc) begin
                    csum     <= csum ^ bus.w_in_data;
                    n_words  <= (ADDR_W+1)'(n_full);
                    word_idx <= '0;
                    if ({1'b0, n_full} > DEPTH_L) begin
                        state     <= S_ERR;
                        bus.w_err <= 1'b1;
                        rdy       <= 1'b0;
                    end else if (n_full == 16'd0) begin
                        state <= S_CSUM;
                    end else begin
                        state <= S_DATA;
                    end
                end
                S_DATA: if (acc) begin
                    csum <= csum ^ bus.w_in_data;
                    if (word_done) begin
                        bus.w_we <= 1'b1;
                        bus.w_wa <= word_idx[ADDR_W-1:0];
                        bus.w_wd <= word;
                        word_idx <= idx_nxt;
                        if (idx_nxt == n_words) state <= S_CSUM;
                    end
                end
                S_CSUM: if (acc) begin
                    rdy <= 1'b0;
                    if (bus.w_in_data == csum) begin
                        state           <= S_DONE;
                        bus.w_done      <= 1'b1;
                        bus.w_cpu_rst_n <= 1'b1;
                    end else begin
                        state     <= S_ERR;
                        bus.w_err <= 1'b1;
                    end
                end
                S_DONE, S_ERR: if (restart_ok) begin
                    state           <= S_HDR0;
                    cnt_lo          <= '0;
                    csum            <= '0;
                    n_words         <= '0;
                    word_idx        <= '0;
                    rdy             <= 1'b1;
                    bus.w_cpu_rst_n <= 1'b0;
                    bus.w_done      <= 1'b0;
                    bus.w_err       <= 1'b0;
                end
                default: state <= S_HDR0;
            endcase
        end
    end
endmodule

// File: tb/tb_m_imem_loader.sv
// Directed bench for m_imem_loader: table of whole-image loads plus reset/restart sequences.
module tb_m_imem_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    m_imem_loader_if #(.ADDR_W(12)) bus ();

    m_imem_loader #(.ADDR_W(12), .DEPTH(4096)) dut (
        .w_clk   (clk),
        .w_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [11:0] wq_a [$];
    logic [31:0] wq_d [$];

    always @(posedge clk) begin
        if (bus.w_we) begin
            wq_a.push_back(bus.w_wa);
            wq_d.push_back(bus.w_wd);
        end
    end

    typedef struct {
        string        name;
        logic [127:0] s;      // first byte in the top bits
        int           len;
        bit           gaps;
        int           nw;
        logic [31:0]  wd0;
        logic [31:0]  wd1;
        logic         done;
        logic         err;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.w_in_valid = 1'b0;
        bus.w_in_data  = 8'h00;
        bus.w_restart  = 1'b0;
        @(negedge clk);
        wq_a.delete();
        wq_d.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send(input logic [7:0] b, input bit gaps);
        int tmo;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                bus.w_in_valid = 1'b0;
                @(negedge clk);
            end
        end
        bus.w_in_valid = 1'b1;
        bus.w_in_data  = b;
        tmo = 0;
        while (!bus.w_in_ready && tmo < 20) begin
            @(negedge clk);
            tmo++;
        end
        if (tmo >= 20) chk("ready_timeout", 32'(bus.w_in_ready), 32'd1);
        @(negedge clk);
        bus.w_in_valid = 1'b0;
    endtask

    task automatic send_range(input logic [127:0] s, input int from, input int to, input bit gaps);
        for (int i = from; i < to; i++) send(s[127 - 8*i -: 8], gaps);
    endtask

    task automatic chk_writes(input string nm, input int nw, input logic [31:0] wd0, input logic [31:0] wd1);
        chk({nm, "_nwrites"}, 32'(wq_a.size()), 32'(nw));
        for (int i = 0; i < nw && i < wq_a.size(); i++) begin
            chk({nm, "_wa"}, 32'(wq_a[i]), 32'(i));
            chk({nm, "_wd"}, wq_d[i], (i == 0) ? wd0 : wd1);
        end
    endtask

    localparam logic [127:0] NORMAL = {88'h02_00_13_00_00_00_93_00_50_00_D2, 40'h0};

    initial begin
        bus.w_in_valid = 1'b0;
        bus.w_in_data  = 8'h00;
        bus.w_restart  = 1'b0;

        vecs[0] = '{"normal",   NORMAL, 11, 1'b0, 2, 32'h00000013, 32'h00500093, 1'b1, 1'b0};
        vecs[1] = '{"badcsum",  {88'h02_00_13_00_00_00_93_00_50_00_D3, 40'h0}, 11, 1'b0, 2,
                    32'h00000013, 32'h00500093, 1'b0, 1'b1};
        vecs[2] = '{"empty",    {24'h00_00_00, 104'h0}, 3, 1'b0, 0, 32'h0, 32'h0, 1'b1, 1'b0};
        vecs[3] = '{"oversize", {16'h01_10, 112'h0}, 2, 1'b0, 0, 32'h0, 32'h0, 1'b0, 1'b1};
        vecs[4] = '{"gaps",     NORMAL, 11, 1'b1, 2, 32'h00000013, 32'h00500093, 1'b1, 1'b0};

        do_reset();
        chk("rst_ready", 32'(bus.w_in_ready), 32'd1);
        chk("rst_we", 32'(bus.w_we), 32'd0);
        chk("rst_wa", 32'(bus.w_wa), 32'd0);
        chk("rst_wd", bus.w_wd, 32'd0);
        chk("rst_cpu_rst_n", 32'(bus.w_cpu_rst_n), 32'd0);
        chk("rst_done", 32'(bus.w_done), 32'd0);
        chk("rst_err", 32'(bus.w_err), 32'd0);

        foreach (vecs[k]) begin
            do_reset();
            send_range(vecs[k].s, 0, vecs[k].len, vecs[k].gaps);
            // done/err must appear on the very edge that accepted the last byte
            chk({vecs[k].name, "_done"}, 32'(bus.w_done), 32'(vecs[k].done));
            chk({vecs[k].name, "_err"}, 32'(bus.w_err), 32'(vecs[k].err));
            chk({vecs[k].name, "_cpu_rst_n"}, 32'(bus.w_cpu_rst_n), 32'(vecs[k].done));
            chk({vecs[k].name, "_ready"}, 32'(bus.w_in_ready), 32'd0);
            repeat (3) @(negedge clk);
            chk_writes(vecs[k].name, vecs[k].nw, vecs[k].wd0, vecs[k].wd1);
            chk({vecs[k].name, "_done_hold"}, 32'(bus.w_done), 32'(vecs[k].done));
        end

        // Reset mid-load after five bytes, then a clean reload.
        do_reset();
        send_range(NORMAL, 0, 5, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(bus.w_in_ready), 32'd1);
        chk("midrst_we", 32'(bus.w_we), 32'd0);
        chk("midrst_cpu_rst_n", 32'(bus.w_cpu_rst_n), 32'd0);
        chk("midrst_done", 32'(bus.w_done), 32'd0);
        chk("midrst_err", 32'(bus.w_err), 32'd0);
        @(negedge clk);
        wq_a.delete();
        wq_d.delete();
        rst_n = 1'b1;
        @(negedge clk);
        send_range(NORMAL, 0, 4, 1'b0);
        // restart outside DONE/ERR has no effect
        bus.w_restart = 1'b1;
        @(negedge clk);
        bus.w_restart = 1'b0;
        send_range(NORMAL, 4, 11, 1'b0);
        chk("reload_done", 32'(bus.w_done), 32'd1);
        chk("reload_cpu_rst_n", 32'(bus.w_cpu_rst_n), 32'd1);
        repeat (2) @(negedge clk);
        chk_writes("reload", 2, 32'h00000013, 32'h00500093);

        // Restart from DONE.
        bus.w_restart = 1'b1;
        @(negedge clk);
        bus.w_restart = 1'b0;
        chk("restart_cpu_rst_n", 32'(bus.w_cpu_rst_n), 32'd0);
        chk("restart_ready", 32'(bus.w_in_ready), 32'd1);
        chk("restart_done", 32'(bus.w_done), 32'd0);
        // and the loader is usable again: empty image after restart
        wq_a.delete();
        wq_d.delete();
        send_range({24'h00_00_00, 104'h0}, 0, 3, 1'b0);
        chk("restart_empty_done", 32'(bus.w_done), 32'd1);
        repeat (2) @(negedge clk);
        chk("restart_empty_nwrites", 32'(wq_a.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
